// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles the requester handshakes, the FIFO write port and grant status.
// Latency: none, wires only.
// Backpressure: carried by req_ready (towards requesters) and full (from the FIFO).
// Modports: master = requesters + FIFO side (the environment), slave = the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         w_data;
  logic                          grant_valid;
  logic [2:0]                    grant_id;
  logic                          pkt_done;
  logic [CNT_WIDTH-1:0]          pkt_beats;

  modport master (
    output req_valid, req_last, req_data, full,
    input  req_ready, w_en, w_data, grant_valid, grant_id, pkt_done, pkt_beats
  );

  modport slave (
    input  req_valid, req_last, req_data, full,
    output req_ready, w_en, w_data, grant_valid, grant_id, pkt_done, pkt_beats
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked sharing of one async-FIFO write port.
// Latency: 1 cycle from req_valid to grant, then one beat per cycle; 1 idle cycle between packets.
// Backpressure: full drops req_ready of the owner and stalls writes while the grant is held.
// Ports: w_clk, w_rst_n (async, active low); bus (slave modport) carries req_valid/req_last/
//   req_data/req_ready per requester, full/w_en/w_data for the FIFO and
//   grant_valid/grant_id/pkt_done/pkt_beats as status.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]           state;
  logic                 grant_valid_q;
  logic [2:0]           grant_id_q;
  logic [2:0]           last_id_q;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 pkt_done_q;
  logic [CNT_WIDTH-1:0] pkt_beats_q;

  logic [IW-1:0]        gsel;
  logic                 in_lock;
  logic                 pick_found;
  logic [2:0]           pick_id;
  int                   scan;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]   ready;
  logic                 wr_beat;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign gsel    = grant_id_q[IW-1:0];
  assign in_lock = (state == LOCK);

  // Round-robin pick: the requester just after the previous owner has top priority,
  // so a requester that finished a packet goes to the back of the line.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = (int'(last_id_q) + k) % NUM_REQ;
      if (!pick_found && bus.req_valid[scan[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = 3'(scan);
      end
    end
  end

  // Owner mux and ready fan-out; non-owners never see ready.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gsel == IW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ready[i]  = in_lock && !bus.full;
      end
    end
  end

  assign wr_beat = in_lock && sel_valid && !bus.full;
  assign cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNT_WIDTH'(1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state         <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_id_q     <= 3'(NUM_REQ - 1);
      beat_cnt      <= '0;
      pkt_done_q    <= 1'b0;
      pkt_beats_q   <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state         <= LOCK;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_id;
          end
        end
        LOCK: begin
          // A stalled or silent owner keeps the grant; only a written last beat releases it.
          if (wr_beat) begin
            if (sel_last) begin
              state         <= IDLE;
              grant_valid_q <= 1'b0;
              last_id_q     <= grant_id_q;
              pkt_done_q    <= 1'b1;
              pkt_beats_q   <= cnt_inc;
              beat_cnt      <= '0;
            end else begin
              beat_cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state         <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.w_en        = wr_beat;
  assign bus.w_data      = in_lock ? sel_data : '0;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.pkt_beats   = pkt_beats_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: packet requesters + FIFO full driver around fifo_wr_arbiter.
// Expected behaviour comes from an owner/last-owner/beat-count model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic w_clk = 1'b0;
  logic w_rst_n = 1'b0;
  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Requester drivers
  bit          en[N];
  bit          drop[N];
  int          len_cfg[N];   // 0 = random length 1..5
  int          cur_len[N];
  int          beat[N];
  logic [7:0]  dat[N];
  int          gap_pct = 0;
  int          full_pct = 0;
  bit          full_force = 1'b0;

  // Reference model
  bit          m_lock;
  int          m_owner;
  int          m_last;
  int          m_cnt;
  bit          m_done;
  int          m_beats;
  logic        exp_w_en;
  logic [N-1:0] exp_ready;
  logic [7:0]  exp_wdata;

  function automatic int new_len(int i);
    if (len_cfg[i] == 0) return int'($urandom_range(5, 1));
    return len_cfg[i];
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_done = 1'b0; m_beats = 0;
  endtask

  task automatic reset_drivers();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      cur_len[i] = new_len(i);
      dat[i] = 8'($urandom);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = en[i] && !drop[i] && (int'($urandom_range(99, 0)) >= gap_pct);
      bus.req_last[i]  = (beat[i] == cur_len[i] - 1);
      bus.req_data[i*DW +: DW] = dat[i];
    end
    bus.full = full_force || (int'($urandom_range(99, 0)) < full_pct);
  endtask

  task automatic comb_expect();
    exp_ready = '0;
    exp_w_en  = m_lock && bus.req_valid[m_owner] && !bus.full;
    if (m_lock && !bus.full) exp_ready[m_owner] = 1'b1;
    exp_wdata = m_lock ? bus.req_data[m_owner*DW +: DW] : 8'h00;
  endtask

  // One clock: advance model and drivers across the edge, drive new inputs, return at negedge.
  task automatic tick();
    bit acc[N];
    bit n_lock, n_done;
    int n_owner, n_last, n_cnt, n_beats, c;
    for (int i = 0; i < N; i++) acc[i] = bus.req_valid[i] && exp_ready[i];
    n_lock = m_lock; n_owner = m_owner; n_last = m_last; n_cnt = m_cnt;
    n_done = 1'b0; n_beats = m_beats;
    if (!m_lock) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!n_lock && bus.req_valid[c]) begin n_lock = 1'b1; n_owner = c; end
      end
    end else if (exp_w_en) begin
      if (bus.req_last[m_owner]) begin
        n_lock = 1'b0; n_last = m_owner; n_done = 1'b1; n_cnt = 0;
        n_beats = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end else begin
        n_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
    end
    @(posedge w_clk);
    #1;
    m_lock = n_lock; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
    m_done = n_done; m_beats = n_beats;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (beat[i] == cur_len[i] - 1) begin beat[i] = 0; cur_len[i] = new_len(i); end
        else beat[i]++;
        dat[i] = 8'($urandom);
      end
    end
    drive_inputs();
    comb_expect();
    @(negedge w_clk);
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    model_reset();
    reset_drivers();
    drive_inputs();
    comb_expect();
    repeat (2) @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  task automatic setup(bit all_en, int len);
    for (int i = 0; i < N; i++) begin en[i] = all_en; drop[i] = 1'b0; len_cfg[i] = len; end
    gap_pct = 0; full_pct = 0; full_force = 1'b0;
  endtask

  task automatic test_reset();
    setup(1'b1, 3);
    @(negedge w_clk);
    w_rst_n = 1'b0;
    model_reset(); reset_drivers(); drive_inputs(); comb_expect();
    @(negedge w_clk);
    tests++; if (bus.w_en !== 1'b0) begin fails++; $display("FAIL reset w_en: got %b want 0", bus.w_en); end
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset req_ready: got %b want 0000", bus.req_ready); end
    tests++; if (bus.grant_valid !== 1'b0) begin fails++; $display("FAIL reset grant_valid: got %b want 0", bus.grant_valid); end
    tests++; if (bus.grant_id !== 3'd0) begin fails++; $display("FAIL reset grant_id: got %0d want 0", bus.grant_id); end
    tests++; if (bus.pkt_done !== 1'b0) begin fails++; $display("FAIL reset pkt_done: got %b want 0", bus.pkt_done); end
    tests++; if (bus.pkt_beats !== 8'd0) begin fails++; $display("FAIL reset pkt_beats: got %0d want 0", bus.pkt_beats); end
    w_rst_n = 1'b1;
    tick();
    tests++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd0) begin fails++; $display("FAIL first_grant: got v=%b id=%0d want v=1 id=0", bus.grant_valid, bus.grant_id); end
    tests++; if (bus.w_en !== 1'b1) begin fails++; $display("FAIL first_write w_en: got %b want 1", bus.w_en); end
    tests++; if (bus.w_data !== dat[0]) begin fails++; $display("FAIL first_write w_data: got %h want %h", bus.w_data, dat[0]); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit prev_gv;
    setup(1'b1, 3);
    do_reset();
    prev_gv = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      tests++; if (bus.w_en !== exp_w_en) begin fails++; $display("FAIL rr w_en: got %b want %b t=%0t", bus.w_en, exp_w_en, $time); end
      tests++; if (bus.req_ready !== exp_ready) begin fails++; $display("FAIL rr req_ready: got %b want %b t=%0t", bus.req_ready, exp_ready, $time); end
      tests++; if (bus.w_data !== exp_wdata) begin fails++; $display("FAIL rr w_data: got %h want %h t=%0t", bus.w_data, exp_wdata, $time); end
      tests++; if (bus.grant_valid !== m_lock) begin fails++; $display("FAIL rr grant_valid: got %b want %b t=%0t", bus.grant_valid, m_lock, $time); end
      tests++; if (bus.pkt_done !== m_done) begin fails++; $display("FAIL rr pkt_done: got %b want %b t=%0t", bus.pkt_done, m_done, $time); end
      if (bus.pkt_done) begin
        tests++; if (bus.pkt_beats !== 8'd3) begin fails++; $display("FAIL rr pkt_beats: got %0d want 3", bus.pkt_beats); end
      end
      if (bus.grant_valid && !prev_gv) order.push_back(int'(bus.grant_id));
      prev_gv = bus.grant_valid;
    end
    tests++;
    if (order.size() < 5) begin fails++; $display("FAIL rr grant_count: got %0d want >=5", order.size()); end
    else for (int k = 0; k < 5; k++) begin
      tests++; if (order[k] != exp_order[k]) begin fails++; $display("FAIL rr grant_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]); end
    end
  endtask

  task automatic test_full_stall();
    bit found, done;
    int writes;
    setup(1'b0, 4);
    en[1] = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_lock && m_owner == 1 && m_cnt == 1 && exp_w_en) found = 1'b1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL full setup: got no beat 2 from requester 1 want one within 20 cycles"); end
    else begin
      full_force = 1'b1;
      for (int c = 0; c < 5; c++) begin
        tick();
        tests++; if (bus.w_en !== 1'b0 || bus.req_ready !== 4'b0000) begin fails++; $display("FAIL full stall: got w_en=%b rdy=%b want 0/0000", bus.w_en, bus.req_ready); end
        tests++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd1) begin fails++; $display("FAIL full hold: got v=%b id=%0d want v=1 id=1", bus.grant_valid, bus.grant_id); end
      end
      full_force = 1'b0;
      writes = 0; done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
        tick();
        tests++; if (bus.w_en !== exp_w_en) begin fails++; $display("FAIL full w_en: got %b want %b", bus.w_en, exp_w_en); end
        tests++; if (bus.w_data !== exp_wdata) begin fails++; $display("FAIL full w_data: got %h want %h", bus.w_data, exp_wdata); end
        if (bus.w_en === 1'b1) writes++;
        if (bus.pkt_done === 1'b1) begin
          done = 1'b1;
          tests++; if (bus.pkt_beats !== 8'd4) begin fails++; $display("FAIL full pkt_beats: got %0d want 4", bus.pkt_beats); end
        end
      end
      tests++; if (!done || writes != 2) begin fails++; $display("FAIL full resume: got done=%b writes=%0d want 1/2", done, writes); end
    end
  endtask

  task automatic test_valid_drop();
    bit found, prev_gv, got;
    int next_id;
    setup(1'b0, 4);
    en[2] = 1'b1;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_lock && m_owner == 2 && m_cnt == 1 && exp_w_en) found = 1'b1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL drop setup: got no beat 2 from requester 2 want one within 20 cycles"); end
    else begin
      en[0] = 1'b1; drop[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        tests++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd2) begin fails++; $display("FAIL drop hold: got v=%b id=%0d want v=1 id=2", bus.grant_valid, bus.grant_id); end
        tests++; if (bus.req_ready[0] !== 1'b0) begin fails++; $display("FAIL drop rdy0: got %b want 0", bus.req_ready[0]); end
        tests++; if (bus.w_en !== 1'b0) begin fails++; $display("FAIL drop w_en: got %b want 0", bus.w_en); end
      end
      drop[2] = 1'b0;
      prev_gv = 1'b1; got = 1'b0; next_id = -1;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        tests++; if (bus.w_en !== exp_w_en) begin fails++; $display("FAIL drop w_en_model: got %b want %b", bus.w_en, exp_w_en); end
        tests++; if (bus.req_ready !== exp_ready) begin fails++; $display("FAIL drop req_ready: got %b want %b", bus.req_ready, exp_ready); end
        if (bus.grant_valid === 1'b1 && !prev_gv) begin got = 1'b1; next_id = int'(bus.grant_id); end
        prev_gv = bus.grant_valid;
      end
      tests++; if (!got || next_id != 0) begin fails++; $display("FAIL drop next_grant: got %0d want 0", next_id); end
    end
  endtask

  task automatic test_single_beat();
    int wr_at[$];
    setup(1'b0, 1);
    en[3] = 1'b1;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick();
      tests++; if (bus.w_en !== exp_w_en) begin fails++; $display("FAIL single w_en: got %b want %b", bus.w_en, exp_w_en); end
      tests++; if (bus.w_data !== exp_wdata) begin fails++; $display("FAIL single w_data: got %h want %h", bus.w_data, exp_wdata); end
      if (bus.w_en === 1'b1) wr_at.push_back(c);
      if (bus.grant_valid === 1'b1) begin
        tests++; if (bus.grant_id !== 3'd3) begin fails++; $display("FAIL single grant_id: got %0d want 3", bus.grant_id); end
      end
      if (bus.pkt_done === 1'b1) begin
        tests++; if (bus.pkt_beats !== 8'd1) begin fails++; $display("FAIL single pkt_beats: got %0d want 1", bus.pkt_beats); end
      end
    end
    tests++; if (wr_at.size() != 10) begin fails++; $display("FAIL single write_count: got %0d want 10", wr_at.size()); end
    for (int k = 1; k < wr_at.size(); k++) begin
      tests++; if (wr_at[k] - wr_at[k-1] != 2) begin fails++; $display("FAIL single spacing: got %0d want 2", wr_at[k] - wr_at[k-1]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit found;
    setup(1'b1, 4);
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_lock && m_cnt == 1 && exp_w_en) found = 1'b1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rstmid setup: got no mid-packet write want one within 20 cycles"); end
    else begin
      #2 w_rst_n = 1'b0;
      #1;
      tests++; if (bus.w_en !== 1'b0) begin fails++; $display("FAIL rstmid w_en: got %b want 0", bus.w_en); end
      tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL rstmid req_ready: got %b want 0000", bus.req_ready); end
      tests++; if (bus.grant_valid !== 1'b0) begin fails++; $display("FAIL rstmid grant_valid: got %b want 0", bus.grant_valid); end
      model_reset(); reset_drivers(); drive_inputs(); comb_expect();
      @(negedge w_clk);
      w_rst_n = 1'b1;
      tick();
      tests++; if (bus.grant_valid !== 1'b1 || bus.grant_id !== 3'd0) begin fails++; $display("FAIL rstmid regrant: got v=%b id=%0d want v=1 id=0", bus.grant_valid, bus.grant_id); end
    end
  endtask

  task automatic test_random();
    setup(1'b1, 0);
    gap_pct = 30; full_pct = 25;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 49) for (int i = 0; i < N; i++) en[i] = ($urandom_range(3, 0) != 0);
      tick();
      tests++; if (bus.w_en !== exp_w_en) begin fails++; $display("FAIL rand w_en: got %b want %b t=%0t", bus.w_en, exp_w_en, $time); end
      tests++; if (bus.req_ready !== exp_ready) begin fails++; $display("FAIL rand req_ready: got %b want %b t=%0t", bus.req_ready, exp_ready, $time); end
      tests++; if (bus.w_data !== exp_wdata) begin fails++; $display("FAIL rand w_data: got %h want %h t=%0t", bus.w_data, exp_wdata, $time); end
      tests++; if (bus.grant_valid !== m_lock) begin fails++; $display("FAIL rand grant_valid: got %b want %b t=%0t", bus.grant_valid, m_lock, $time); end
      if (m_lock) begin
        tests++; if (bus.grant_id !== 3'(m_owner)) begin fails++; $display("FAIL rand grant_id: got %0d want %0d t=%0t", bus.grant_id, m_owner, $time); end
      end
      tests++; if (bus.pkt_done !== m_done) begin fails++; $display("FAIL rand pkt_done: got %b want %b t=%0t", bus.pkt_done, m_done, $time); end
      if (m_done) begin
        tests++; if (bus.pkt_beats !== 8'(m_beats)) begin fails++; $display("FAIL rand pkt_beats: got %0d want %0d t=%0t", bus.pkt_beats, m_beats, $time); end
      end
    end
    gap_pct = 0; full_pct = 0;
  endtask

  initial begin
    setup(1'b0, 1);
    model_reset();
    reset_drivers();
    drive_inputs();
    comb_expect();
    test_reset();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_single_beat();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ packet-based requesters in the write clock domain. It grants one requester at a time and holds the grant until that requester's last beat is written, so packets never interleave in the FIFO. It drives the FIFO write enable and data and honours the FIFO full flag; the write pointer/full logic is unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO word width
CNT_WIDTH, 8, width of the per-packet beat counter

Ports:
w_clk  in  1  write-domain clock
w_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req_valid
req_data  in  NUM_REQ*DATA_WIDTH  packed beat data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  beat accepted when req_valid[i] && req_ready[i]
full  in  1  FIFO full flag (write domain)
w_en  out  1  FIFO write enable
w_data  out  DATA_WIDTH  FIFO write data
grant_valid  out  1  a requester currently holds the grant
grant_id  out  3  index of the granted requester (valid when grant_valid)
pkt_done  out  1  one-cycle pulse, registered, after a last beat is written
pkt_beats  out  CNT_WIDTH  beat count of the just-finished packet, valid with pkt_done

Behaviour:
- Two-state FSM: IDLE, LOCK.
- Reset (async, immediate): state=IDLE; grant_valid=0; grant_id=0; last_id=NUM_REQ-1; beat_cnt=0; pkt_done=0; pkt_beats=0. Combinational outputs w_en=0 and req_ready=0 follow immediately.
- IDLE: req_ready=0, w_en=0. If any req_valid is set, choose the first set bit scanning from (last_id+1) mod NUM_REQ upward with wrap. At the next edge: state=LOCK, grant_id=chosen, grant_valid=1. Arbitration latency is 1 cycle. If no req_valid is set, stay in IDLE.
- LOCK (g = grant_id): req_ready[g] = !full; every other req_ready = 0. w_en = req_valid[g] && !full. w_data = req_data[g] at all times in LOCK. w_data = 0 in IDLE.
- Write beat: w_en=1 at a clock edge. On each write beat, beat_cnt increments, saturating at all-ones.
- Write beat with req_last[g]=1: at that edge, state=IDLE, grant_valid=0, last_id=g, pkt_done=1 on the next cycle, pkt_beats=beat_cnt+1 (saturating), beat_cnt=0. One idle bubble cycle exists between packets.
- full=1 in LOCK: w_en=0 and req_ready[g]=0; the grant is held and no state changes. Writing resumes in the first cycle that full=0.
- req_valid[g] deasserted mid-packet: the grant is held indefinitely. There is no timeout and no write.
- req_last is ignored unless the beat is actually written.
- Single-beat packet (valid+last): written on the first LOCK cycle with !full; pkt_beats=1.
- Reset asserted mid-packet: the partial packet already in the FIFO is not removed. Requesters must restart after reset.
- At most one w_en per cycle. req_ready is never asserted for a non-granted requester.

Test Plan:
- Reset with all req_valid=1 -> w_en=0, req_ready=0, grant_valid=0. Release reset -> grant_id=0 after 1 cycle, then w_en=1 with w_data=req_data[0].
- Requesters 0–3 each send continuous 3-beat packets, full=0 -> grant order 0,1,2,3,0. Each packet has 3 contiguous writes, one bubble cycle between packets, pkt_done pulses with pkt_beats=3.
- Requester 1 mid-packet (beat 2 of 4) with full held high for 5 cycles -> w_en=0 and req_ready=0 for those 5 cycles, grant_id stays 1, then beats 3 and 4 are written, pkt_beats=4.
- Requester 2 drops valid for 3 cycles mid-packet while requester 0 is valid -> grant stays 2, req_ready[0]=0, and no writes occur until requester 2 resumes.
- Only requester 3 active, with single-beat packets back-to-back -> each beat is written every 2 cycles, pkt_beats=1, and grant_id=3 repeatedly.
- Assert w_rst_n low during LOCK -> w_en, req_ready and grant_valid drop in the same cycle with no clock edge. After release, the first grant goes to requester 0.
